// File: rtl/spi_temp_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame/clock settings
// used by the sensor readers in this design.
package spi_temp_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_CLK_DIV    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI master: pulses tick every CLK_DIV enabled
// cycles and restarts from zero whenever the owner changes state.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_in_p,
  input  logic rst_in_p,
  input  logic clr_in_p,
  input  logic en_in_p,
  output logic tick_out_p
);

  localparam int HC_W = $clog2(CLK_DIV + 1);

  logic [HC_W-1:0] hc_reg;

  assign tick_out_p = en_in_p && (hc_reg == HC_W'(CLK_DIV - 1));

  always_ff @(posedge clk_in_p or posedge rst_in_p) begin
    if (rst_in_p) begin
      hc_reg <= '0;
    end else if (clr_in_p) begin
      hc_reg <= '0;
    end else if (en_in_p) begin
      if (tick_out_p) begin
        hc_reg <= '0;
      end else begin
        hc_reg <= hc_reg + HC_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_temp_reader.sv
// SPI mode-0 master that reads one MSB-first frame from the temperature
// sensor per start request; SCLK is a registered, tick-paced output.
module spi_temp_reader
  import spi_temp_pkg::*;
#(
  parameter int CLK_DIV    = SPI_CLK_DIV,
  parameter int FRAME_BITS = SPI_FRAME_BITS
) (
  input  logic                  clk_in_p,
  input  logic                  rst_in_p,
  input  logic                  start_in_p,
  input  logic                  miso_in_p,
  output logic                  sclk_out_p,
  output logic                  cs_n_out_p,
  output logic [FRAME_BITS-1:0] data_out_p,
  output logic                  valid_out_p,
  output logic                  busy_out_p
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);

  spi_state_t            state_reg, state_next;
  logic                  sclk_reg, sclk_next;
  logic                  cs_n_reg, cs_n_next;
  logic                  busy_reg, busy_next;
  logic                  valid_reg, valid_next;
  logic [BC_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [FRAME_BITS-1:0] shift_data_reg, shift_data_next;
  logic [FRAME_BITS-1:0] data_reg, data_next;
  logic                  tick;
  logic                  state_change;

  assign state_change = (state_next != state_reg);

  spi_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk_in_p  (clk_in_p),
    .rst_in_p  (rst_in_p),
    .clr_in_p  (state_change),
    .en_in_p   (state_reg != IDLE),
    .tick_out_p(tick)
  );

  always_ff @(posedge clk_in_p or posedge rst_in_p) begin
    if (rst_in_p) begin
      state_reg      <= IDLE;
      sclk_reg       <= 1'b0;
      cs_n_reg       <= 1'b1;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      bit_cnt_reg    <= '0;
      shift_data_reg <= '0;
      data_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      sclk_reg       <= sclk_next;
      cs_n_reg       <= cs_n_next;
      busy_reg       <= busy_next;
      valid_reg      <= valid_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_data_reg <= shift_data_next;
      data_reg       <= data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sclk_next       = sclk_reg;
    cs_n_next       = cs_n_reg;
    busy_next       = busy_reg;
    valid_next      = 1'b0;
    bit_cnt_next    = bit_cnt_reg;
    shift_data_next = shift_data_reg;
    data_next       = data_reg;

    case (state_reg)
      IDLE: begin
        if (start_in_p) begin
          state_next   = SETUP;
          cs_n_next    = 1'b0;
          busy_next    = 1'b1;
          bit_cnt_next = '0;
        end
      end
      SETUP: begin
        if (tick) begin
          state_next      = SHIFT;
          sclk_next       = 1'b1;
          shift_data_next = (shift_data_reg << 1) | FRAME_BITS'(miso_in_p);
          bit_cnt_next    = bit_cnt_reg + BC_W'(1);
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_reg) begin
            sclk_next = 1'b0;
          end else if (bit_cnt_reg == BC_W'(FRAME_BITS)) begin
            // Last pulse has finished its full low phase; CS hold begins.
            state_next = HOLD;
          end else begin
            sclk_next       = 1'b1;
            shift_data_next = (shift_data_reg << 1) | FRAME_BITS'(miso_in_p);
            bit_cnt_next    = bit_cnt_reg + BC_W'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_next = IDLE;
          cs_n_next  = 1'b1;
          busy_next  = 1'b0;
          data_next  = shift_data_reg;
          valid_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sclk_out_p  = sclk_reg;
  assign cs_n_out_p  = cs_n_reg;
  assign data_out_p  = data_reg;
  assign valid_out_p = valid_reg;
  assign busy_out_p  = busy_reg;

endmodule
